// File: rtl/mm_stream_host_pkg.sv
// Shared types, protocol constants and flat-vector index helpers for the
// matmul pin-protocol host (mm_stream_host and mm_beat_sel).
package mm_stream_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_CHECK   = 3'd4,
      ST_FIN     = 3'd5
   } mm_state_t;

   localparam int         MM_N         = 3;
   localparam int         MM_LOAD_BIT  = 6;
   localparam logic [7:0] MM_DONE_MARK = 8'hFF;
   localparam int         MM_BEATS     = 2 * MM_N * MM_N;

   // LSB offset of element (r,c) in a row-major flat vector of w-bit elements
   function automatic int elem_lsb(input int r, input int c, input int n, input int w);
      return (r * n + c) * w;
   endfunction

   function automatic int idx_lsb(input int i, input int w);
      return i * w;
   endfunction

endpackage

// File: rtl/mm_beat_sel.sv
// Combinational beat mux: beat index 0..N*N-1 picks A row-major,
// N*N..2*N*N-1 picks B row-major; out-of-range indices give zero.
module mm_beat_sel
   import mm_stream_host_pkg::*;
#(
   parameter int N      = 3,
   parameter int DATA_W = 6,
   parameter int IDX_W  = 5
) (
   input  logic [N*N*DATA_W-1:0] a_flat,
   input  logic [N*N*DATA_W-1:0] b_flat,
   input  logic [IDX_W-1:0]      beat_idx,
   output logic [DATA_W-1:0]     word
);

   always_comb begin
      word = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (beat_idx == IDX_W'(r * N + c))
               word = a_flat[elem_lsb(r, c, N, DATA_W) +: DATA_W];
            if (beat_idx == IDX_W'(N * N + r * N + c))
               word = b_flat[elem_lsb(r, c, N, DATA_W) +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/mm_stream_host.sv
// Host driver for the matmul pin protocol: streams A then B as load beats and
// captures N*N result bytes. Define MM_DONE_CHECK_EN to add the done-marker check.
module mm_stream_host
   import mm_stream_host_pkg::*;
#(
   parameter int N             = MM_N,
   parameter int DATA_W        = 6,
   parameter int RES_W         = 8,
   parameter int CAPTURE_DELAY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [N*N*DATA_W-1:0] a_flat,
   input  logic [N*N*DATA_W-1:0] b_flat,
   output logic                  busy,
   output logic                  done,
   output logic [N*N*RES_W-1:0]  res_flat,
   output logic                  err_done,
   output logic [7:0]            mm_ui,
   input  logic [7:0]            mm_uo
);

   localparam int NN        = N * N;
   localparam int BEATS     = (N == MM_N) ? MM_BEATS : 2 * NN;
   localparam int BEAT_W    = $clog2(BEATS);
   localparam int CAP_W     = (NN > 1) ? $clog2(NN) : 1;
   localparam int WAIT_W    = (CAPTURE_DELAY > 2) ? $clog2(CAPTURE_DELAY - 1) : 1;
   localparam int WAIT_LAST = (CAPTURE_DELAY > 1) ? CAPTURE_DELAY - 2 : 0;

   mm_state_t              state;
   mm_state_t              nxt;
   logic [BEAT_W-1:0]      beat_cnt;
   logic [CAP_W-1:0]       cap_cnt;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [NN*DATA_W-1:0]   a_snap;
   logic [NN*DATA_W-1:0]   b_snap;
   logic [NN*DATA_W-1:0]   sel_a;
   logic [NN*DATA_W-1:0]   sel_b;
   logic [BEAT_W-1:0]      sel_idx;
   logic [DATA_W-1:0]      sel_word;
   logic [7:0]             mm_ui_q;
   logic [7:0]             mm_ui_d;
   logic                   busy_q;
   logic                   busy_d;
   logic                   done_q;
   logic                   done_d;
   logic [NN*RES_W-1:0]    res_q;
   logic                   start_ok;

   assign start_ok = (state == ST_IDLE) && start && !abort;

   // Beat 0 leaves on the same edge that takes the snapshot, so it is read
   // from the live operands; every later beat comes from the snapshot.
   assign sel_a   = (state == ST_IDLE) ? a_flat : a_snap;
   assign sel_b   = (state == ST_IDLE) ? b_flat : b_snap;
   assign sel_idx = (state == ST_IDLE) ? '0 : beat_cnt + 1'b1;

   mm_beat_sel #(
      .N      (N),
      .DATA_W (DATA_W),
      .IDX_W  (BEAT_W)
   ) u_beat_sel (
      .a_flat   (sel_a),
      .b_flat   (sel_b),
      .beat_idx (sel_idx),
      .word     (sel_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (abort) begin
         nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (start) nxt = ST_LOAD;
            ST_LOAD:    if (beat_cnt == BEAT_W'(BEATS - 1))
                           nxt = (CAPTURE_DELAY > 1) ? ST_WAIT : ST_CAPTURE;
            ST_WAIT:    if (wait_cnt == WAIT_W'(WAIT_LAST)) nxt = ST_CAPTURE;
`ifdef MM_DONE_CHECK_EN
            ST_CAPTURE: if (cap_cnt == CAP_W'(NN - 1)) nxt = ST_CHECK;
            ST_CHECK:   nxt = ST_FIN;
`else
            ST_CAPTURE: if (cap_cnt == CAP_W'(NN - 1)) nxt = ST_FIN;
`endif
            ST_FIN:     nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
         endcase
      end
   end

   // Registered outputs are decoded from the next state so they line up with it.
   always_comb begin
      mm_ui_d = '0;
      if (nxt == ST_LOAD) begin
         mm_ui_d[MM_LOAD_BIT]  = 1'b1;
         mm_ui_d[DATA_W-1:0]   = sel_word;
      end
      busy_d = (nxt != ST_IDLE);
      done_d = (state == ST_FIN) && !abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         wait_cnt <= '0;
         cap_cnt  <= '0;
         mm_ui_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_q    <= '0;
      end else begin
         mm_ui_q  <= mm_ui_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         beat_cnt <= (state == ST_LOAD && nxt == ST_LOAD) ? beat_cnt + 1'b1 : '0;
         wait_cnt <= (state == ST_WAIT && nxt == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         cap_cnt  <= (state == ST_CAPTURE && nxt == ST_CAPTURE) ? cap_cnt + 1'b1 : '0;
         if (state == ST_CAPTURE && !abort)
            res_q[idx_lsb(int'(cap_cnt), RES_W) +: RES_W] <= RES_W'(mm_uo);
      end
   end

   always_ff @(posedge clk) begin
      if (start_ok) begin
         a_snap <= a_flat;
         b_snap <= b_flat;
      end
   end

`ifdef MM_DONE_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            err_q <= 1'b0;
      else if (start_ok)                     err_q <= 1'b0;
      else if (state == ST_CHECK && !abort)  err_q <= (mm_uo != MM_DONE_MARK);
   end

   assign err_done = err_q;
`else
   assign err_done = 1'b0;
`endif

   assign mm_ui    = mm_ui_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign res_flat = res_q;

endmodule

// File: doc/mm_stream_host.md
Name: mm_stream_host

Overview:
- Host-side transmitter/collector for the 3x3 matmul pin protocol.
- Snapshots two operand matrices and streams them onto the matmul input pins as 18 load beats (A then B, row-major).
- Then captures the N*N result bytes from the matmul output pins in a fixed-latency window.
- Used as the on-board or bench driver sitting in front of the matmul tile.

Parameters:
- N, 3, matrix dimension (beats = 2*N*N, results = N*N)
- DATA_W, 6, operand element width; occupies mm_ui[DATA_W-1:0]
- RES_W, 8, captured result width per element
- CAPTURE_DELAY, 2, edges from the edge sampling the final load beat to the edge sampling the first result; legal range is >= 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- a_flat  in  N*N*DATA_W  matrix A; element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
- b_flat  in  N*N*DATA_W  matrix B, same packing
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- res_flat  out  N*N*RES_W  captured C; element (r,c) at [(r*N+c)*RES_W +: RES_W]
- err_done  out  1  done-marker mismatch flag (see Optional Feature)
- mm_ui  out  8  to matmul: bit7 = 0, bit6 = load strobe, bits5:0 = data
- mm_uo  in  8  from matmul result pins

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE.
  - mm_ui, busy, done, err_done, res_flat and all counters are 0 immediately, without waiting for a clock edge.
- All outputs are registered.
- FSM states: IDLE, LOAD, WAIT, CAPTURE, CHECK (only with the feature), FIN.
- IDLE:
  - mm_ui = 0.
  - On start: snapshot a_flat/b_flat into internal registers, clear beat_cnt, go to LOAD.
  - Operand changes after that edge are ignored.
- LOAD, 2*N*N cycles:
  - beat k is driven as mm_ui = {1'b0, 1'b1, word_k}.
  - k < N*N: word_k = A[k/N][k%N].
  - k >= N*N: word_k = B[(k-N*N)/N][(k-N*N)%N].
  - First beat appears the cycle after start is sampled.
  - Beats are on consecutive cycles with no gaps.
- WAIT:
  - Entered after the final beat; mm_ui = 0.
  - Lasts CAPTURE_DELAY-1 cycles; with CAPTURE_DELAY = 1, WAIT is skipped.
- CAPTURE, N*N cycles:
  - mm_uo is sampled into res_flat element i = cap_cnt on each edge, consecutively.
  - With CAPTURE_DELAY = 2, the first result is sampled 2 edges after the edge ending the last beat cycle.
- FIN:
  - done = 1 for exactly one cycle, then IDLE.
  - busy falls the same cycle done is asserted.
- Results in res_flat:
  - Held until the next capture overwrites them.
  - Not cleared by start.
- start while busy: ignored, no queuing.
- abort:
  - Any state goes to IDLE next edge; mm_ui = 0 from that edge.
  - No done pulse; partially captured res_flat elements stay as written.
  - abort and start in the same cycle in IDLE: abort wins, stay IDLE.
- Counter widths: beat_cnt covers 0..2*N*N-1; cap_cnt covers 0..N*N-1. Terminal value is checked, never wrapped.
- Total start-to-done latency with defaults: 1 + 18 + 1 + 9 + 1 = 30 cycles (done pulse at cycle t+30 when start is sampled at cycle t). Verify the exact number against RTL; the bench checks it.

Optional Feature:
- Macro MM_DONE_CHECK_EN.
- Defined:
  - After CAPTURE, go to CHECK for one cycle and sample mm_uo.
  - If mm_uo != 8'hFF (the matmul done marker), set err_done; it stays high until the next start or reset.
  - done pulses regardless of the check result.
  - Latency is +1 cycle.
- Undefined: CHECK is absent; err_done is tied 0.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Constants: MM_LOAD_BIT = 6, MM_DONE_MARK = 8'hFF, MM_BEATS = 2*N*N.
  - Flat-index helper functions for element (r,c) offsets.
- One natural sub-module: mm_beat_sel, a combinational mux from the operand snapshot plus beat index to a DATA_W word. The FSM and capture logic stay in the top.

Test Plan:
- Load sequence: A = identity, B = 1..9 row-major, start -> mm_ui sequence 0x41,0x40,0x40,0x40,0x41,0x40,0x40,0x40,0x41, then 0x41..0x49 on consecutive cycles; mm_ui = 0x00 afterwards.
- Capture: bench model drives 0x10..0x18 on mm_uo in the CAPTURE_DELAY = 2 window -> res_flat elements 0..8 = 0x10..0x18; single done pulse; busy low the same cycle.
- start pulsed during LOAD beat 5 -> beat stream unchanged, exactly one done; operand change mid-load has no effect.
- abort asserted at beat 12 -> mm_ui = 0 next cycle, IDLE, no done; a following start sends the full 18 beats.
- rst_n low during CAPTURE -> mm_ui, busy and res_flat are 0 before the next clock edge; after release, state is IDLE.
- MM_DONE_CHECK_EN: mm_uo = 0xFF in CHECK -> err_done = 0; mm_uo = 0xFE -> err_done = 1, held until the next start, which clears it.
